// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, operand forwarding, jump
// flushes, halt drain, and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int PC_W         = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_uses_rs1,
  input  logic             dec_uses_rs2,
  input  logic [4:0]       dec_rd,
  input  logic             dec_reg_wrenable,
  input  logic             dec_mem_to_reg,
  input  logic             dec_halt,
  input  logic             ex_should_jump,
  input  logic [PC_W-1:0]  ex_jump_pc,
  output logic             stall,
  output logic             flush,
  output logic             pc_sel,
  output logic [PC_W-1:0]  next_pc_tgt,
  output logic             pc_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  // Handshake: the decode instruction is consumed (enters EX) in the cycle
  // where dec_valid=1 and the controller is in RUN with stall=0 and flush=0;
  // any other cycle a bubble enters EX and decode must re-present its word.
  state_t           state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             ex_we_q, ex_we_d;
  logic             ex_load_q, ex_load_d;
  logic [4:0]       mem_rd_q, mem_rd_d;
  logic             mem_we_q, mem_we_d;
  logic             flush_pend_q, flush_pend_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic go, run, accepted, halt_acc;
  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;

  function automatic logic slot_hit(input logic [4:0] rs, input logic uses,
                                    input logic [4:0] rd, input logic we);
    return uses && we && (rd != 5'd0) && (rs == rd);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return 2'b01;
    else if (mem_hit) return 2'b10;
    else              return 2'b00;
  endfunction

  always_comb begin
    go          = !rst;
    run         = go && (state_q == ST_RUN);
    ex_hit_a    = slot_hit(dec_rs1, dec_uses_rs1, ex_rd_q, ex_we_q);
    ex_hit_b    = slot_hit(dec_rs2, dec_uses_rs2, ex_rd_q, ex_we_q);
    mem_hit_a   = slot_hit(dec_rs1, dec_uses_rs1, mem_rd_q, mem_we_q);
    mem_hit_b   = slot_hit(dec_rs2, dec_uses_rs2, mem_rd_q, mem_we_q);

    pc_sel      = run && ex_should_jump;
    next_pc_tgt = pc_sel ? ex_jump_pc : '0;
    // flush_pend covers the one-cycle synchronous ROM fetch after a jump.
    flush       = run && (ex_should_jump || flush_pend_q);
    stall       = run && dec_valid && !flush && ex_load_q && (ex_hit_a || ex_hit_b);

    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (go && !stall && !flush) begin
      fwd_a = fwd_sel(ex_hit_a, mem_hit_a);
      fwd_b = fwd_sel(ex_hit_b, mem_hit_b);
    end

    accepted = run && dec_valid && !stall && !flush;
    halt_acc = accepted && dec_halt;
    pc_hold  = go && (halt_acc || (state_q != ST_RUN));
  end

  always_comb begin
    ex_rd_d      = accepted ? dec_rd : 5'd0;
    ex_we_d      = accepted && dec_reg_wrenable;
    ex_load_d    = accepted && dec_mem_to_reg;
    mem_rd_d     = ex_rd_q;
    mem_we_d     = ex_we_q;
    flush_pend_d = pc_sel;

    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (halt_acc) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DW'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) state_d = ST_HALTED;
        else                   drain_cnt_d = drain_cnt_q - DW'(1);
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
    halted_d = (state_d == ST_HALTED);

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (pc_sel && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      drain_cnt_q  <= '0;
      ex_rd_q      <= 5'd0;
      ex_we_q      <= 1'b0;
      ex_load_q    <= 1'b0;
      mem_rd_q     <= 5'd0;
      mem_we_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      halted_q     <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      ex_rd_q      <= ex_rd_d;
      ex_we_q      <= ex_we_d;
      ex_load_q    <= ex_load_d;
      mem_rd_q     <= mem_rd_d;
      mem_we_q     <= mem_we_d;
      flush_pend_q <= flush_pend_d;
      halted_q     <= halted_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign state       = state_q;
  assign halted      = halted_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized scoreboard bench for hazard_ctrl against a cycle-history
// reference model; narrow counters so saturation is reached.
module tb_hazard_ctrl;
  localparam int PC_W = 5;
  localparam int DRN  = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, dec_valid, dec_uses_rs1, dec_uses_rs2, dec_reg_wrenable;
  logic dec_mem_to_reg, dec_halt, ex_should_jump;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic [PC_W-1:0] ex_jump_pc, next_pc_tgt;
  logic stall, flush, pc_sel, pc_hold, halted;
  logic [1:0] fwd_a, fwd_b, state;
  logic [CW-1:0] stall_count, flush_count;

  hazard_ctrl #(.PC_W(PC_W), .DRAIN_CYCLES(DRN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2), .dec_rd(dec_rd),
    .dec_reg_wrenable(dec_reg_wrenable), .dec_mem_to_reg(dec_mem_to_reg),
    .dec_halt(dec_halt), .ex_should_jump(ex_should_jump), .ex_jump_pc(ex_jump_pc),
    .stall(stall), .flush(flush), .pc_sel(pc_sel), .next_pc_tgt(next_pc_tgt),
    .pc_hold(pc_hold), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic rst, dv;
    logic [4:0] rs1, rs2;
    logic u1, u2;
    logic [4:0] rd;
    logic we, ld, halt, jmp;
    logic [4:0] jpc;
  } stim_t;

  typedef struct packed {
    logic chk;
    logic stall, flush, pc_sel;
    logic [4:0] tgt;
    logic pc_hold;
    logic [1:0] fa, fb;
    logic halted;
    logic [1:0] st;
    logic [CW-1:0] sc, fc;
  } exp_t;

  localparam int EW = $bits(exp_t);
  logic [EW-1:0] exp_q[$];

  // reference model: history of what entered EX each cycle, plus halt time
  typedef struct {
    bit we;
    bit [4:0] rd;
    bit ld;
  } ins_t;
  ins_t hist[$];
  bit   prev_jmp;
  int   halt_at;
  int   cyc;
  int   m_sc, m_fc;
  bit   known;

  int total = 0;
  int bad = 0;

  function automatic bit hit(bit [4:0] rs, bit uses, ins_t i);
    return uses && i.we && (i.rd != 0) && (rs == i.rd);
  endfunction

  function automatic int model_mode();
    if (halt_at < 0) return 0;
    if (cyc - halt_at <= DRN) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    ins_t b;
    b.we = 0; b.rd = 0; b.ld = 0;
    hist.delete();
    hist.push_back(b);
    hist.push_back(b);
    prev_jmp = 0;
    halt_at  = -1;
    m_sc = 0;
    m_fc = 0;
  endtask

  task automatic model_eval(input stim_t s);
    exp_t e;
    ins_t n;
    int mode;
    bit run, a1e, a2e, a1m, a2m, acc;
    e = '0;
    acc = 0;
    mode = model_mode();
    e.chk    = known;
    e.st     = 2'(mode);
    e.halted = (mode == 2);
    e.sc     = CW'(m_sc);
    e.fc     = CW'(m_fc);
    run = !s.rst && (mode == 0);
    if (!s.rst) begin
      a1e = hit(s.rs1, s.u1, hist[0]);
      a2e = hit(s.rs2, s.u2, hist[0]);
      a1m = hit(s.rs1, s.u1, hist[1]);
      a2m = hit(s.rs2, s.u2, hist[1]);
      e.pc_sel = run && s.jmp;
      e.tgt    = e.pc_sel ? s.jpc : 5'd0;
      e.flush  = run && (s.jmp || prev_jmp);
      e.stall  = run && s.dv && !e.flush && hist[0].ld && (a1e || a2e);
      if (!e.stall && !e.flush) begin
        e.fa = a1e ? 2'b01 : (a1m ? 2'b10 : 2'b00);
        e.fb = a2e ? 2'b01 : (a2m ? 2'b10 : 2'b00);
      end
      acc = run && s.dv && !e.stall && !e.flush;
      e.pc_hold = (acc && s.halt) || (mode != 0);
    end
    exp_q.push_back(e);

    if (s.rst) begin
      model_reset();
      known = 1;
    end else begin
      n.we = acc && s.we;
      n.rd = s.rd;
      n.ld = acc && s.ld;
      hist.push_front(n);
      void'(hist.pop_back());
      prev_jmp = run && s.jmp;
      if (acc && s.halt) halt_at = cyc + 0;
      if (e.stall && m_sc < CMAX) m_sc++;
      if (e.pc_sel && m_fc < CMAX) m_fc++;
    end
    cyc++;
  endtask

  // driver
  task automatic apply(input stim_t s);
    rst = s.rst; dec_valid = s.dv; dec_rs1 = s.rs1; dec_rs2 = s.rs2;
    dec_uses_rs1 = s.u1; dec_uses_rs2 = s.u2; dec_rd = s.rd;
    dec_reg_wrenable = s.we; dec_mem_to_reg = s.ld; dec_halt = s.halt;
    ex_should_jump = s.jmp; ex_jump_pc = s.jpc;
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    apply(s);
    model_eval(s);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t instr(bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2,
                                  bit [4:0] rd, bit we, bit ld);
    stim_t s;
    s = '0;
    s.dv = 1; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
    s.rd = rd; s.we = we; s.ld = ld;
    return s;
  endfunction

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("stall", 32'(stall), 32'(mon_e.stall));
      chk("flush", 32'(flush), 32'(mon_e.flush));
      chk("pc_sel", 32'(pc_sel), 32'(mon_e.pc_sel));
      chk("next_pc_tgt", 32'(next_pc_tgt), 32'(mon_e.tgt));
      chk("pc_hold", 32'(pc_hold), 32'(mon_e.pc_hold));
      chk("fwd_a", 32'(fwd_a), 32'(mon_e.fa));
      chk("fwd_b", 32'(fwd_b), 32'(mon_e.fb));
      if (mon_e.chk) begin
        chk("halted", 32'(halted), 32'(mon_e.halted));
        chk("state", 32'(state), 32'(mon_e.st));
        chk("stall_count", 32'(stall_count), 32'(mon_e.sc));
        chk("flush_count", 32'(flush_count), 32'(mon_e.fc));
      end
    end
  end

  initial begin
    stim_t s;
    known = 0;
    cyc = 0;
    model_reset();
    s = idle();
    s.rst = 1;
    apply(s);

    // reset held two cycles with halt and jump asserted
    s = idle(); s.rst = 1; s.dv = 1; s.halt = 1; s.jmp = 1; s.jpc = 5'd9;
    step(s);
    step(s);
    step(idle());

    // load-use then forward from MEM
    step(instr(0, 0, 0, 0, 5, 1, 1));
    step(instr(5, 1, 0, 0, 6, 1, 0));
    step(instr(5, 1, 0, 0, 6, 1, 0));
    step(idle());

    // ALU forwarding EX then MEM, and x0 never forwards
    step(instr(0, 0, 0, 0, 3, 1, 0));
    step(instr(0, 0, 3, 1, 4, 1, 0));
    step(instr(0, 0, 3, 1, 0, 0, 0));
    step(instr(0, 0, 0, 0, 0, 1, 0));
    step(instr(0, 1, 0, 1, 1, 1, 0));
    step(idle());

    // jump coinciding with load-use hazard
    step(instr(0, 0, 0, 0, 7, 1, 1));
    s = instr(7, 1, 0, 0, 2, 1, 0); s.jmp = 1; s.jpc = 5'd12;
    step(s);
    step(idle());
    step(idle());

    // halt drain with a jump pulse inside DRAIN, then reset out of HALTED
    s = idle(); s.dv = 1; s.halt = 1;
    step(s);
    step(idle());
    s = idle(); s.jmp = 1; s.jpc = 5'd20;
    step(s);
    for (int i = 0; i < 5; i++) step(idle());
    s = idle(); s.rst = 1;
    step(s);
    step(idle());

    // halt with simultaneous jump is not accepted
    s = idle(); s.dv = 1; s.halt = 1; s.jmp = 1; s.jpc = 5'd3;
    step(s);
    for (int i = 0; i < 3; i++) step(idle());

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s = '0;
      s.rst  = (model_mode() == 2) ? ($urandom_range(0, 7) == 0)
                                   : ($urandom_range(0, 199) == 0);
      s.dv   = ($urandom_range(0, 9) != 0);
      s.rs1  = 5'($urandom_range(0, 3));
      s.rs2  = 5'($urandom_range(0, 3));
      s.u1   = 1'($urandom_range(0, 1));
      s.u2   = 1'($urandom_range(0, 1));
      s.rd   = 5'($urandom_range(0, 3));
      s.we   = ($urandom_range(0, 3) != 0);
      s.ld   = 1'($urandom_range(0, 1));
      s.halt = ($urandom_range(0, 39) == 0);
      s.jmp  = ($urandom_range(0, 9) == 0);
      s.jpc  = 5'($urandom_range(0, 31));
      step(s);
    end

    @(posedge clk);
    #1;
    apply(idle());
    @(negedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
